cfu_quantizer_pipe: RTL

- Multi-lane, fully pipelined successor to cfu_quantizer for the accel_imgc CFU.
- Requantizes LANES int32 accumulators per beat into OUT_W-bit signed outputs, using the TFLite MultiplyByQuantizedMultiplier arithmetic.
- Bias/mul/shift are fetched per lane from an internal per-channel parameter table; offset/min/max are per-tensor config.
- Valid/ready streaming replaces the old external two-step control sequencing.

---
 rtl/cfu_quantizer_pipe_if.sv | 25 ++
 rtl/cfu_quantizer_pipe.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/cfu_quantizer_pipe_if.sv
// Streaming handshake bundle for cfu_quantizer_pipe: one accumulator beat in,
// one requantized beat out, each with valid/ready.
interface cfu_quantizer_pipe_if #(
  parameter int LANES = 4,
  parameter int CH_W  = 6,
  parameter int OUT_W = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic [32*LANES-1:0]      in_data;
  logic [CH_W-1:0]          in_ch;
  logic                     out_valid;
  logic                     out_ready;
  logic [OUT_W*LANES-1:0]   out_data;

  modport master (
    output in_valid, in_data, in_ch, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_ch, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/cfu_quantizer_pipe.sv
// Multi-lane TFLite requantizer: acc + bias, optional left shift, saturating
// rounding doubling high multiply, rounding right shift, offset and clamp.
module cfu_quantizer_pipe #(
  parameter int LANES  = 4,
  parameter int NUM_CH = 64,
  parameter int OUT_W  = 8,
  parameter int CH_W   = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                param_we,
  input  logic [CH_W-1:0]     param_addr,
  input  logic signed [31:0]  param_bias,
  input  logic signed [31:0]  param_mul,
  input  logic signed [5:0]   param_shift,
  input  logic signed [31:0]  cfg_offset,
  input  logic signed [31:0]  cfg_min,
  input  logic signed [31:0]  cfg_max,
  input  logic                cfg_per_channel,
  cfu_quantizer_pipe_if.slave strm
);

  function automatic logic signed [31:0] srdhm(input logic signed [31:0] a,
                                               input logic signed [31:0] b);
    logic signed [63:0] ab;
    logic signed [63:0] s;
    if (a == 32'sh8000_0000 && b == 32'sh8000_0000) return 32'sh7fff_ffff;
    ab = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    s  = ab + ((ab >= 64'sd0) ? 64'sd1073741824 : -64'sd1073741823);
    // bias negative sums so the arithmetic shift truncates toward zero
    if (s < 64'sd0) s = s + 64'sd2147483647;
    return 32'(s >>> 31);
  endfunction

  function automatic logic signed [31:0] rdiv_pot(input logic signed [31:0] y,
                                                  input logic [4:0] rs);
    logic [31:0]        mask;
    logic [31:0]        rem;
    logic [31:0]        thr;
    logic signed [31:0] z;
    mask = (32'd1 << rs) - 32'd1;
    rem  = y & mask;
    thr  = (mask >> 1) + {31'd0, y[31]};
    z    = y >>> rs;
    if (rem > thr) z = z + 32'sd1;
    return z;
  endfunction

  logic signed [31:0] tbl_bias_q  [NUM_CH];
  logic signed [31:0] tbl_mul_q   [NUM_CH];
  logic signed [5:0]  tbl_shift_q [NUM_CH];

  logic s1_valid_q, s2_valid_q, s3_valid_q;
  logic signed [31:0] s1_x_q [LANES];
  logic signed [31:0] s1_mul_q [LANES];
  logic [4:0]         s1_rs_q [LANES];
  logic signed [31:0] s1_off_q, s1_min_q, s1_max_q;
  logic signed [31:0] s2_y_q [LANES];
  logic [4:0]         s2_rs_q [LANES];
  logic signed [31:0] s2_off_q, s2_min_q, s2_max_q;
  logic [OUT_W*LANES-1:0] s3_data_q;

  logic [CH_W-1:0]    lane_ch [LANES];
  logic signed [5:0]  lane_sh [LANES];
  logic signed [31:0] lane_sum [LANES];
  logic signed [31:0] lane_w [LANES];
  logic signed [31:0] s1_x_d [LANES];
  logic signed [31:0] s1_mul_d [LANES];
  logic [4:0]         s1_rs_d [LANES];
  logic signed [31:0] s2_y_d [LANES];
  logic [OUT_W*LANES-1:0] s3_data_d;

  logic en;
  logic accept;

  // A full output stage that is not being drained freezes the whole pipe.
  assign en            = !(s3_valid_q && !strm.out_ready);
  assign strm.in_ready = en && !rst;
  assign accept        = strm.in_valid && strm.in_ready;
  assign strm.out_valid = s3_valid_q;
  assign strm.out_data  = s3_data_q;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_ch[i]  = cfg_per_channel ? strm.in_ch + CH_W'(i) : strm.in_ch;
      lane_sh[i]  = tbl_shift_q[lane_ch[i]];
      lane_sum[i] = $signed(strm.in_data[32*i +: 32]) + tbl_bias_q[lane_ch[i]];
      s1_mul_d[i] = tbl_mul_q[lane_ch[i]];
      s1_x_d[i]   = (lane_sh[i] > 6'sd0) ? (lane_sum[i] <<< lane_sh[i][4:0]) : lane_sum[i];
      s1_rs_d[i]  = lane_sh[i][5] ? 5'(-lane_sh[i]) : 5'd0;
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      s2_y_d[i] = srdhm(s1_x_q[i], s1_mul_q[i]);
    end
  end

  always_comb begin
    s3_data_d = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_w[i] = rdiv_pot(s2_y_q[i], s2_rs_q[i]) + s2_off_q;
      if (lane_w[i] < s2_min_q) lane_w[i] = s2_min_q;
      // max applied last so an inverted window yields cfg_max
      if (lane_w[i] > s2_max_q) lane_w[i] = s2_max_q;
      s3_data_d[OUT_W*i +: OUT_W] = lane_w[i][OUT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        tbl_bias_q[c]  <= '0;
        tbl_mul_q[c]   <= '0;
        tbl_shift_q[c] <= '0;
      end
    end else if (param_we) begin
      tbl_bias_q[param_addr]  <= param_bias;
      tbl_mul_q[param_addr]   <= param_mul;
      tbl_shift_q[param_addr] <= param_shift;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s3_data_q  <= '0;
    end else if (en) begin
      s1_valid_q <= accept;
      s2_valid_q <= s1_valid_q;
      s3_valid_q <= s2_valid_q;
      if (s2_valid_q) s3_data_q <= s3_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      if (accept) begin
        for (int i = 0; i < LANES; i++) begin
          s1_x_q[i]   <= s1_x_d[i];
          s1_mul_q[i] <= s1_mul_d[i];
          s1_rs_q[i]  <= s1_rs_d[i];
        end
        s1_off_q <= cfg_offset;
        s1_min_q <= cfg_min;
        s1_max_q <= cfg_max;
      end
      if (s1_valid_q) begin
        for (int i = 0; i < LANES; i++) begin
          s2_y_q[i]  <= s2_y_d[i];
          s2_rs_q[i] <= s1_rs_q[i];
        end
        s2_off_q <= s1_off_q;
        s2_min_q <= s1_min_q;
        s2_max_q <= s1_max_q;
      end
    end
  end

endmodule
